// File: rtl/mtr_pwm_if.sv
// Speed command and H-bridge drive bundle between the steering stage and the
// motor PWM driver.
interface mtr_pwm_if;
    logic        go;
    logic [11:0] lft_speed;
    logic [11:0] rght_speed;
    logic        lft_fwd;
    logic        lft_rev;
    logic        rght_fwd;
    logic        rght_rev;
    logic        pwm_sync;

    modport master (
        output go, lft_speed, rght_speed,
        input  lft_fwd, lft_rev, rght_fwd, rght_rev, pwm_sync
    );

    modport slave (
        input  go, lft_speed, rght_speed,
        output lft_fwd, lft_rev, rght_fwd, rght_rev, pwm_sync
    );
endinterface

// File: rtl/mtr_pwm_drv.sv
// Two-wheel H-bridge PWM driver: edge-aligned 2048-clock PWM with dead time
// and a forced one-period coast gap on every direction reversal.
module mtr_pwm_drv #(
    parameter int unsigned DEADTIME = 8
) (
    input  logic      clk,
    input  logic      rst,
    mtr_pwm_if.slave  bus_io
);

    localparam int unsigned NumWheels = 2;
    localparam logic [11:0] MaxD      = 12'(2048 - 2 * DEADTIME);
    localparam logic [12:0] DeadT     = 13'(DEADTIME);

    typedef enum logic [1:0] {StCoast, StFwd, StRev, StGap} wheel_st_e;

    logic [10:0] cnt_q, cnt_d;
    logic        wrap;
    logic        sync_q, sync_d;

    logic [11:0] speed    [NumWheels];
    logic [11:0] mag      [NumWheels];
    logic [11:0] duty_new [NumWheels];
    logic        sign_new [NumWheels];
    logic [11:0] duty_q   [NumWheels];
    logic [11:0] duty_d   [NumWheels];
    wheel_st_e   st_q     [NumWheels];
    wheel_st_e   st_d     [NumWheels];
    logic        on       [NumWheels];
    logic        fwd_q    [NumWheels];
    logic        fwd_d    [NumWheels];
    logic        rev_q    [NumWheels];
    logic        rev_d    [NumWheels];

    assign speed[0] = bus_io.lft_speed;
    assign speed[1] = bus_io.rght_speed;

    assign wrap   = (cnt_q == 11'd2047);
    assign cnt_d  = cnt_q + 11'd1;
    assign sync_d = (cnt_d == 11'd0);

    // 12'h800 negates to itself, which reads as the unsigned magnitude 2048.
    always_comb begin
        for (int w = 0; w < NumWheels; w++) begin
            sign_new[w] = speed[w][11];
            mag[w]      = speed[w][11] ? (~speed[w] + 12'd1) : speed[w];
            duty_new[w] = (mag[w] > MaxD) ? MaxD : mag[w];
            duty_d[w]   = wrap ? duty_new[w] : duty_q[w];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 11'd0;
            sync_q <= 1'b0;
            for (int w = 0; w < NumWheels; w++) begin
                st_q[w]   <= StCoast;
                duty_q[w] <= 12'd0;
                fwd_q[w]  <= 1'b0;
                rev_q[w]  <= 1'b0;
            end
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
            for (int w = 0; w < NumWheels; w++) begin
                st_q[w]   <= st_d[w];
                duty_q[w] <= duty_d[w];
                fwd_q[w]  <= fwd_d[w];
                rev_q[w]  <= rev_d[w];
            end
        end
    end

    // Direction decisions happen only at the wrap; go low coasts immediately.
    always_comb begin
        for (int w = 0; w < NumWheels; w++) begin
            st_d[w] = st_q[w];
            if (!bus_io.go) begin
                st_d[w] = StCoast;
            end else if (wrap) begin
                unique case (st_q[w])
                    StCoast, StGap: begin
                        if (duty_new[w] == 12'd0) st_d[w] = StCoast;
                        else                      st_d[w] = sign_new[w] ? StRev : StFwd;
                    end
                    StFwd: begin
                        if (duty_new[w] == 12'd0) st_d[w] = StCoast;
                        else                      st_d[w] = sign_new[w] ? StGap : StFwd;
                    end
                    StRev: begin
                        if (duty_new[w] == 12'd0) st_d[w] = StCoast;
                        else                      st_d[w] = sign_new[w] ? StRev : StGap;
                    end
                    default: st_d[w] = StCoast;
                endcase
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NumWheels; w++) begin
            on[w]    = ({2'b00, cnt_q} >= DeadT) &&
                       ({2'b00, cnt_q} < (DeadT + {1'b0, duty_q[w]}));
            fwd_d[w] = on[w] && (st_q[w] == StFwd);
            rev_d[w] = on[w] && (st_q[w] == StRev);
        end
    end

    assign bus_io.lft_fwd  = fwd_q[0];
    assign bus_io.lft_rev  = rev_q[0];
    assign bus_io.rght_fwd = fwd_q[1];
    assign bus_io.rght_rev = rev_q[1];
    assign bus_io.pwm_sync = sync_q;

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Bench for mtr_pwm_drv: directed scenarios plus a randomized run, all checked
// against a period-level model of drive direction and pulse window.
module tb_mtr_pwm_drv;

    localparam int DT   = 8;
    localparam int MAXD = 2048 - 2 * DT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mtr_pwm_if bus ();

    mtr_pwm_drv #(.DEADTIME(DT)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: period counter, latched duty, and drive direction (+1 fwd, -1 rev, 0 none).
    int   m_cnt;
    int   m_duty [2];
    int   m_dir  [2];
    logic e_fwd  [2];
    logic e_rev  [2];
    logic e_sync;

    function automatic int speed_of(int w);
        logic signed [11:0] v;
        v = (w == 0) ? bus.lft_speed : bus.rght_speed;
        return int'(v);
    endfunction

    function automatic logic [4:0] dut_vec();
        return {bus.lft_fwd, bus.lft_rev, bus.rght_fwd, bus.rght_rev, bus.pwm_sync};
    endfunction

    function automatic logic [4:0] exp_vec();
        return {e_fwd[0], e_rev[0], e_fwd[1], e_rev[1], e_sync};
    endfunction

    // Advance one clock and update the model with the inputs seen at that edge.
    task automatic tick();
        int s, mag, d, dir;
        bit on;
        @(posedge clk);
        if (rst) begin
            m_cnt  = 0;
            e_sync = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_duty[w] = 0;
                m_dir[w]  = 0;
                e_fwd[w]  = 1'b0;
                e_rev[w]  = 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                on       = (m_cnt >= DT) && (m_cnt < DT + m_duty[w]);
                e_fwd[w] = on && (m_dir[w] == 1);
                e_rev[w] = on && (m_dir[w] == -1);
            end
            for (int w = 0; w < 2; w++) begin
                if (m_cnt == 2047) begin
                    s   = speed_of(w);
                    mag = (s < 0) ? -s : s;
                    d   = (mag > MAXD) ? MAXD : mag;
                    dir = (s < 0) ? -1 : 1;
                    m_duty[w] = d;
                    // A period driven one way is never directly followed by the other way.
                    if (!bus.go || d == 0)    m_dir[w] = 0;
                    else if (m_dir[w] == -dir) m_dir[w] = 0;
                    else                       m_dir[w] = dir;
                end else if (!bus.go) begin
                    m_dir[w] = 0;
                end
            end
            m_cnt  = (m_cnt + 1) % 2048;
            e_sync = (m_cnt == 0);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.go = 1'b0; bus.lft_speed = 12'h000; bus.rght_speed = 12'h000;
        do_reset();
        checks++;
        if (dut_vec() !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 5'b0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_idle got=%b exp=%b", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_one_dir(input string name, input logic [11:0] ls, input logic [11:0] rs,
                                input int exp_lf, input int exp_lr,
                                input int exp_rf, input int exp_rr, input int exp_first);
        int lf = 0, lr = 0, rf = 0, rr = 0, first = -1;
        bus.go = 1'b1; bus.lft_speed = ls; bus.rght_speed = rs;
        do_reset();
        for (int i = 0; i < 3 * 2048 - 1; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s_cycle cnt=%0d got=%b exp=%b", name, m_cnt, dut_vec(), exp_vec());
            end
            if (bus.lft_fwd === 1'b1) begin
                lf++;
                if (first < 0) first = m_cnt;
            end
            if (bus.rght_rev === 1'b1 && first < 0) first = m_cnt;
            if (bus.lft_rev === 1'b1)  lr++;
            if (bus.rght_fwd === 1'b1) rf++;
            if (bus.rght_rev === 1'b1) rr++;
        end
        checks++;
        if ({lf, lr, rf, rr} !== {exp_lf, exp_lr, exp_rf, exp_rr}) begin
            errors++;
            $display("FAIL %s_counts got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", name,
                     lf, lr, rf, rr, exp_lf, exp_lr, exp_rf, exp_rr);
        end
        checks++;
        if (first !== exp_first) begin
            errors++; $display("FAIL %s_first_rise got=%0d exp=%0d", name, first, exp_first);
        end
    endtask

    task automatic test_reversal();
        int f [3];
        int r [3];
        bus.go = 1'b1; bus.lft_speed = 12'h100; bus.rght_speed = 12'h000;
        do_reset();
        for (int i = 0; i < 2048; i++) tick();
        for (int p = 0; p < 3; p++) begin
            f[p] = 0; r[p] = 0;
            for (int i = 0; i < 2048; i++) begin
                tick();
                if (p == 0 && m_cnt == 300) bus.lft_speed = 12'hF00;
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL reversal_cycle p=%0d cnt=%0d got=%b exp=%b",
                             p, m_cnt, dut_vec(), exp_vec());
                end
                if (bus.lft_fwd === 1'b1) f[p]++;
                if (bus.lft_rev === 1'b1) r[p]++;
            end
        end
        checks++;
        if ({f[0], r[0], f[1], r[1], f[2], r[2]} !== {32'd256, 32'd0, 32'd0, 32'd0, 32'd0, 32'd256})
        begin
            errors++;
            $display("FAIL reversal_gap got=%0d/%0d %0d/%0d %0d/%0d exp=256/0 0/0 0/256",
                     f[0], r[0], f[1], r[1], f[2], r[2]);
        end
    endtask

    task automatic test_saturation();
        int lf = 0, rr = 0, edge_hi = 0;
        bus.go = 1'b1; bus.lft_speed = 12'h7FF; bus.rght_speed = 12'h800;
        do_reset();
        for (int i = 0; i < 2048; i++) tick();
        for (int i = 0; i < 2048; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sat_cycle cnt=%0d got=%b exp=%b", m_cnt, dut_vec(), exp_vec());
            end
            if (bus.lft_fwd === 1'b1)  lf++;
            if (bus.rght_rev === 1'b1) rr++;
            // Output lags the compare by one clock: high only for cnt 9..2040 here.
            if ((m_cnt <= DT || m_cnt > 2048 - DT) && (bus.lft_fwd !== 1'b0 || bus.rght_rev !== 1'b0))
                edge_hi++;
        end
        checks++;
        if (lf !== MAXD || rr !== MAXD) begin
            errors++; $display("FAIL sat_width got=%0d/%0d exp=%0d/%0d", lf, rr, MAXD, MAXD);
        end
        checks++;
        if (edge_hi !== 0) begin
            errors++; $display("FAIL sat_deadtime got=%0d exp=0", edge_hi);
        end
    endtask

    task automatic test_go_drop();
        int pre = 0, lf = 0, rf = 0, wait_cnt = 0;
        bus.go = 1'b1; bus.lft_speed = 12'h300; bus.rght_speed = 12'h100;
        do_reset();
        for (int i = 0; i < 2048 + 500; i++) tick();
        bus.go = 1'b0;
        tick();
        tick();
        checks++;
        if (dut_vec() & 5'b11110) begin
            errors++; $display("FAIL go_drop_off got=%b exp=0000x", dut_vec());
        end
        while (m_cnt != 1000) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL go_low_cycle cnt=%0d got=%b exp=%b", m_cnt, dut_vec(), exp_vec());
            end
        end
        bus.go = 1'b1;
        while (bus.pwm_sync !== 1'b1 && wait_cnt < 4096) begin
            tick();
            wait_cnt++;
            if (bus.lft_fwd !== 1'b0 || bus.rght_fwd !== 1'b0) pre++;
        end
        checks++;
        if (wait_cnt !== 1048 || pre !== 0) begin
            errors++; $display("FAIL go_resume_wait got=%0d/%0d exp=1048/0", wait_cnt, pre);
        end
        for (int i = 0; i < 2048; i++) begin
            tick();
            if (bus.lft_fwd === 1'b1)  lf++;
            if (bus.rght_fwd === 1'b1) rf++;
        end
        checks++;
        if (lf !== 768 || rf !== 256) begin
            errors++; $display("FAIL go_resume_width got=%0d/%0d exp=768/256", lf, rf);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, drive = 0;
        bus.go = 1'b1; bus.lft_speed = 12'h7FF; bus.rght_speed = 12'h900;
        do_reset();
        for (int i = 0; i < 2048 + 1000; i++) tick();
        checks++;
        if (bus.lft_fwd !== 1'b1 || bus.rght_rev !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre got=%b exp=1001x", dut_vec());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut_vec() !== 5'b0) begin
            errors++; $display("FAIL rst_mid_outputs got=%b exp=00000", dut_vec());
        end
        while (bus.pwm_sync !== 1'b1 && n < 4096) begin
            tick();
            n++;
            if (bus.lft_fwd !== 1'b0 || bus.rght_rev !== 1'b0) drive++;
        end
        checks++;
        if (n !== 2048 || drive !== 0) begin
            errors++; $display("FAIL rst_mid_restart got=%0d/%0d exp=2048/0", n, drive);
        end
    endtask

    function automatic logic [11:0] rand_speed();
        case ($urandom_range(0, 7))
            0:       return 12'h000;
            1:       return 12'h800;
            2:       return 12'h7FF;
            3:       return 12'(-$urandom_range(1, 300));
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic test_random();
        int shoot = 0;
        bus.go = 1'b1; bus.lft_speed = rand_speed(); bus.rght_speed = rand_speed();
        do_reset();
        for (int i = 0; i < 25000; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle i=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
            end
            if ((bus.lft_fwd & bus.lft_rev) !== 1'b0 || (bus.rght_fwd & bus.rght_rev) !== 1'b0)
                shoot++;
            if ($urandom_range(0, 255) == 0)  bus.lft_speed  = rand_speed();
            if ($urandom_range(0, 255) == 0)  bus.rght_speed = rand_speed();
            if ($urandom_range(0, 999) == 0)  bus.go = ~bus.go;
            rst = ($urandom_range(0, 4999) == 0);
        end
        rst = 1'b0;
        checks++;
        if (shoot !== 0) begin
            errors++; $display("FAIL shoot_through got=%0d exp=0", shoot);
        end
    endtask

    initial begin
        bus.go = 1'b0; bus.lft_speed = 12'h000; bus.rght_speed = 12'h000;
        test_reset();
        test_one_dir("fwd", 12'h200, 12'h000, 1024, 0, 0, 0, DT + 1);
        test_one_dir("rev", 12'h000, 12'hF00, 0, 0, 0, 512, DT + 1);
        test_reversal();
        test_saturation();
        test_go_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
